mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, 32, address width; DWIDTH, 32, data width; STARVE_MAX, 4, max consecutive data grants while fetch waits.
REQ-002 Ports SHALL be:
clk  in  1  single clock, rising edge;
rst  in  1  synchronous, active-high reset;
if_req_i  in  1  fetch read request;
if_addr_i  in  AWIDTH  fetch address;
if_gnt_o  out  1  fetch request accepted;
if_rvalid_o  out  1  fetch response valid;
if_rdata_o  out  DWIDTH  fetch read data;
d_req_i  in  1  data request;
d_we_i  in  1  data write (1) / read (0);
d_addr_i  in  AWIDTH  data address;
d_wdata_i  in  DWIDTH  store data;
d_funct3_i  in  3  access size/sign code;
d_gnt_o  out  1  data request accepted;
d_rvalid_o  out  1  data response/write ack valid;
d_rdata_o  out  DWIDTH  data read data;
mem_addr_o  out  AWIDTH  shared memory address;
mem_wdata_o  out  DWIDTH  shared memory write data;
mem_read_en_o  out  1  shared memory read enable;
mem_write_en_o  out  1  shared memory write enable;
mem_funct3_o  out  3  shared memory access code;
mem_data_i  in  DWIDTH  shared memory combinational read data.

Function
REQ-003 The FSM SHALL have states IDLE, SERVE_IF, SERVE_D and RESP.
REQ-004 Grants SHALL be combinational and issued only in IDLE or RESP; at most one gnt is high per cycle.
REQ-005 Arbitration SHALL use fixed priority: data over fetch, subject to REQ-020.
REQ-006 A granted request SHALL be registered (address, wdata, we, funct3; fetch funct3 = 3'b010).
REQ-007 State SHALL become SERVE_D or SERVE_IF on the next edge after a grant.
REQ-008 A requester SHALL hold req and its payload stable until gnt; the requester may drop req in the cycle after gnt.
REQ-009 In SERVE_x the mem_* ports SHALL be driven from the registered request.
REQ-010 mem_read_en_o SHALL be high in SERVE_x for reads; mem_write_en_o SHALL be high for exactly one cycle in SERVE_D for writes.
REQ-011 mem_data_i SHALL be captured at the end of SERVE_x; state then moves to RESP.
REQ-012 In RESP the requester's rvalid SHALL pulse for exactly one cycle with the captured rdata; for a write, d_rdata_o = 0.
REQ-013 Latency SHALL be gnt at cycle T, mem access at T+1, rvalid at T+2; peak throughput is one access per 2 cycles.
REQ-014 In RESP with no grant, the next state SHALL be IDLE.
REQ-015 Outside SERVE_x all mem_* outputs SHALL be 0.
REQ-016 rdata outputs SHALL hold their last value between rvalid pulses.

Reset
REQ-017 While rst is high, state SHALL go to IDLE on the edge, all gnt/rvalid/mem enables SHALL be 0 combinationally, all data outputs 0, and the starvation counter 0.
REQ-018 rst asserted in SERVE_D SHALL suppress the write (mem_write_en_o gated by !rst) and produce no rvalid.
REQ-019 After rst deasserts, the first grant SHALL be possible in that same cycle (IDLE).

Configuration
REQ-020 With MEM_ARB_STARVE_EN defined, a 3-bit counter SHALL increment on each data grant while if_req_i is high and clear on a fetch grant or when if_req_i is low; when counter == STARVE_MAX and both requests are present, fetch SHALL be granted.
REQ-021 Without MEM_ARB_STARVE_EN, strict data priority SHALL apply and the counter SHALL be absent.

Verification
REQ-022 Single fetch: if_req_i=1, if_addr_i=0x01000000, mem_data_i=0x00000013 -> if_gnt_o at T, mem_read_en_o at T+1, if_rvalid_o=1 with if_rdata_o=0x00000013 at T+2.
REQ-023 Store: d_req_i=1, d_we_i=1, d_addr_i=0x02000010, d_wdata_i=0xDEADBEEF, d_funct3_i=3'b010 -> exactly one mem_write_en_o cycle with those values, then d_rvalid_o=1 with d_rdata_o=0.
REQ-024 Collision: both requests high in IDLE -> d_gnt_o=1, if_gnt_o=0; if_gnt_o in the following RESP cycle if data has dropped its request.
REQ-025 Starvation (macro on): d_req_i held high with if_req_i high -> if_gnt_o on the 5th arbitration slot; macro off -> if_gnt_o is never issued.
REQ-026 Reset mid-store: rst=1 during SERVE_D -> mem_write_en_o=0 and no d_rvalid_o; state is IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported combinational memory.
// Optional fetch anti-starvation counter enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic              r_owner_d;
  logic [DWIDTH-1:0] r_if_rdata, r_d_rdata;
  logic              w_slot, w_force_if, w_d_gnt, w_if_gnt, w_serve;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] r_starve_cnt;
`endif

  always_comb begin
    w_slot = (r_state == IDLE || r_state == RESP) && !rst;
`ifdef MEM_ARB_STARVE_EN
    w_force_if = (r_starve_cnt == STARVE_LIM) && if_req_i && d_req_i;
`else
    w_force_if = 1'b0;
`endif
    w_d_gnt  = w_slot && d_req_i && !w_force_if;
    w_if_gnt = w_slot && if_req_i && !w_d_gnt;
    w_serve  = (r_state == SERVE_IF || r_state == SERVE_D) && !rst;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RESP: begin
        if (w_d_gnt)       w_state_nxt = SERVE_D;
        else if (w_if_gnt) w_state_nxt = SERVE_IF;
        else               w_state_nxt = IDLE;
      end
      SERVE_IF, SERVE_D: w_state_nxt = RESP;
      default:           w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch the winner's payload; requesters may drop req right after gnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_owner_d <= 1'b0;
    end else if (w_d_gnt) begin
      r_addr    <= d_addr_i;
      r_wdata   <= d_wdata_i;
      r_we      <= d_we_i;
      r_funct3  <= d_funct3_i;
      r_owner_d <= 1'b1;
    end else if (w_if_gnt) begin
      r_addr    <= if_addr_i;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'b010;
      r_owner_d <= 1'b0;
    end
  end

  // Per-requester read data holds between rvalid pulses; writes return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (r_state == SERVE_IF) begin
      r_if_rdata <= mem_data_i;
    end else if (r_state == SERVE_D) begin
      r_d_rdata <= r_we ? '0 : mem_data_i;
    end
  end

`ifdef MEM_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    if (rst || !if_req_i || w_if_gnt) r_starve_cnt <= 3'd0;
    else if (w_d_gnt)                 r_starve_cnt <= r_starve_cnt + 3'd1;
  end
`endif

  always_comb begin
    if_gnt_o       = w_if_gnt;
    d_gnt_o        = w_d_gnt;
    if_rvalid_o    = (r_state == RESP) && !r_owner_d && !rst;
    d_rvalid_o     = (r_state == RESP) &&  r_owner_d && !rst;
    if_rdata_o     = rst ? '0 : r_if_rdata;
    d_rdata_o      = rst ? '0 : r_d_rdata;
    mem_addr_o     = w_serve ? r_addr   : '0;
    mem_wdata_o    = w_serve ? r_wdata  : '0;
    mem_funct3_o   = w_serve ? r_funct3 : 3'b000;
    mem_read_en_o  = w_serve && !r_we;
    mem_write_en_o = w_serve && r_we && (r_state == SERVE_D);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, load, collision, starvation, reset mid-store.
// Starvation expectations follow MEM_ARB_STARVE_EN when the bench is built with it.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic [2:0]    d_funct3_i, mem_funct3_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_data_i;
  logic          mem_read_en_o, mem_write_en_o;

  int n_tot = 0;
  int n_bad = 0;
  int n_if_gnt, n_d_gnt;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_funct3_i(d_funct3_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_read_en_o(mem_read_en_o),
    .mem_write_en_o(mem_write_en_o), .mem_funct3_o(mem_funct3_o), .mem_data_i(mem_data_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change #1 after the edge, checks happen #2 after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_funct3_i = '0;
    mem_data_i = '0;
    cyc(); cyc();
    // Reset: requests present but everything held off.
    if_req_i = 1'b1; d_req_i = 1'b1; settle();
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_d_gnt", d_gnt_o, 0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
    chk("rst_mem_en", {mem_read_en_o, mem_write_en_o}, 0);

    // Single fetch, granted in the first cycle out of reset.
    cyc(); rst = 1'b0; d_req_i = 1'b0; if_addr_i = 32'h0100_0000; settle();
    chk("f_gnt", {if_gnt_o, d_gnt_o}, 2'b10);
    cyc(); if_req_i = 1'b0; mem_data_i = 32'h0000_0013; settle();
    chk("f_mem", {mem_read_en_o, mem_write_en_o, mem_funct3_o, mem_addr_o}, {2'b10, 3'b010, 32'h0100_0000});
    chk("f_nogntserve", {if_gnt_o, d_gnt_o}, 0);
    cyc(); mem_data_i = 32'hFFFF_FFFF; settle();
    chk("f_rvalid", {if_rvalid_o, d_rvalid_o, if_rdata_o}, {2'b10, 32'h0000_0013});
    chk("f_mem_idle", {mem_read_en_o, mem_addr_o}, 0);
    cyc(); settle();
    chk("f_hold", {if_rvalid_o, if_rdata_o}, {1'b0, 32'h0000_0013});

    // Store.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0200_0010; d_wdata_i = 32'hDEAD_BEEF; d_funct3_i = 3'b010;
    settle();
    chk("s_gnt", {if_gnt_o, d_gnt_o}, 2'b01);
    cyc(); d_req_i = 1'b0; mem_data_i = 32'h1234_5678; settle();
    chk("s_mem", {mem_write_en_o, mem_read_en_o, mem_funct3_o, mem_addr_o, mem_wdata_o},
        {2'b10, 3'b010, 32'h0200_0010, 32'hDEAD_BEEF});
    cyc(); settle();
    chk("s_rvalid", {d_rvalid_o, if_rvalid_o, d_rdata_o}, {2'b10, 32'h0});
    chk("s_we_once", mem_write_en_o, 0);

    // Load, signed-byte code.
    cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0200_0023; d_funct3_i = 3'b000; settle();
    chk("l_gnt", d_gnt_o, 1);
    cyc(); d_req_i = 1'b0; mem_data_i = 32'hA5A5_5A5A; settle();
    chk("l_mem", {mem_read_en_o, mem_write_en_o, mem_funct3_o, mem_addr_o}, {2'b10, 3'b000, 32'h0200_0023});
    cyc(); settle();
    chk("l_rvalid", {d_rvalid_o, d_rdata_o}, {1'b1, 32'hA5A5_5A5A});

    // Collision: data wins, fetch granted in RESP once data drops.
    cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0200_0040; d_funct3_i = 3'b010;
    if_req_i = 1'b1; if_addr_i = 32'h0100_0004; settle();
    chk("c_gnt", {if_gnt_o, d_gnt_o}, 2'b01);
    cyc(); d_req_i = 1'b0; mem_data_i = 32'h0000_0BAD; settle();
    chk("c_serve_d", {mem_addr_o, if_gnt_o}, {32'h0200_0040, 1'b0});
    cyc(); mem_data_i = 32'h0000_0093; settle();
    chk("c_resp", {d_rvalid_o, d_rdata_o, if_gnt_o, d_gnt_o}, {1'b1, 32'h0000_0BAD, 2'b10});
    cyc(); if_req_i = 1'b0; settle();
    chk("c_serve_if", {mem_read_en_o, mem_addr_o}, {1'b1, 32'h0100_0004});
    cyc(); settle();
    chk("c_if_rvalid", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h0000_0093});
    cyc();

    // Starvation: both held; count grants over six arbitration slots.
    n_if_gnt = 0; n_d_gnt = 0;
    d_req_i = 1'b1; d_we_i = 1'b0; if_req_i = 1'b1; settle();
    for (int s = 0; s < 6; s++) begin
      if (s < 4) chk($sformatf("st_slot%0d", s), {if_gnt_o, d_gnt_o}, 2'b01);
`ifdef MEM_ARB_STARVE_EN
      if (s == 4) chk("st_slot4", {if_gnt_o, d_gnt_o}, 2'b10);
`else
      if (s == 4) chk("st_slot4", {if_gnt_o, d_gnt_o}, 2'b01);
`endif
      n_if_gnt += int'(if_gnt_o);
      n_d_gnt  += int'(d_gnt_o);
      cyc(); settle();
      cyc(); settle();
    end
`ifdef MEM_ARB_STARVE_EN
    chk("st_if_cnt", n_if_gnt, 1);
`else
    chk("st_if_cnt", n_if_gnt, 0);
    chk("st_d_cnt", n_d_gnt, 6);
`endif
    d_req_i = 1'b0; if_req_i = 1'b0;
    cyc(); cyc(); cyc();

    // Reset during SERVE_D of a store.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0200_0080; d_wdata_i = 32'hCAFE_F00D; settle();
    chk("r_gnt", d_gnt_o, 1);
    cyc(); d_req_i = 1'b0; rst = 1'b1; settle();
    chk("r_no_write", {mem_write_en_o, mem_addr_o, mem_wdata_o}, 0);
    cyc(); rst = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0100_0008; settle();
    chk("r_no_rvalid", {d_rvalid_o, if_rvalid_o}, 0);
    chk("r_idle_gnt", {if_gnt_o, d_gnt_o}, 2'b10);
    cyc(); if_req_i = 1'b0; settle();
    chk("r_serve_if", {mem_read_en_o, mem_write_en_o, mem_addr_o}, {2'b10, 32'h0100_0008});
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
